// File: rtl/led_pkg.sv
// ============================================================================
//  Package : led_pkg
//  Shared definitions for the LED fade datapath: FSM state encodings of the
//  fade sequencer and the default widths of the PWM and ramp-rate fields.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  // Default width of the PWM counter, duty level and command level.
  localparam int DEFAULT_PWM_BITS  = 8;
  // Default width of the ramp-rate field (clocks-per-step minus one).
  localparam int DEFAULT_RATE_BITS = 16;

  // Fade sequencer FSM state encodings.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pwm_gen.sv
// ============================================================================
//  Module  : pwm_gen
//  Free-running PWM generator. A PWM_BITS-wide counter wraps continuously;
//  the requested duty is copied into a shadow register only at the end of a
//  period so a running period is never disturbed. Output is registered.
//
//  Ports:
//    i_clk      in   system clock
//    i_reset_n  in   asynchronous active-low reset
//    i_duty     in   requested duty level (high clocks per period)
//    o_pwm      out  registered PWM output
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      o_pwm   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // Load on the last count of the period; the new duty takes effect
      // when the counter returns to zero.
      if (pwm_cnt == '1) begin
        shadow <= i_duty;
      end
      o_pwm <= (pwm_cnt < shadow);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fade_sequencer.sv
// ============================================================================
//  Module  : fade_sequencer
//  Accepts brightness commands over valid/ready and ramps the duty level one
//  LSB at a time toward the target, one step every (rate+1) clocks. The
//  level feeds a free-running PWM generator driving the LED pin.
//
//  Ports:
//    i_clk        in   system clock
//    i_reset_n    in   asynchronous active-low reset
//    i_cmd_valid  in   command present
//    o_cmd_ready  out  command can be accepted (high only in IDLE)
//    i_cmd_level  in   target duty level
//    i_cmd_rate   in   clocks-per-step minus one
//    i_abort      in   stop the ramp, hold the current level
//    o_busy       out  ramp in progress
//    o_level      out  current ramp level
//    o_done       out  one-cycle pulse when the target is reached
//    o_led        out  PWM output
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fade_sequencer
  import led_pkg::*;
#(
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int RATE_BITS = DEFAULT_RATE_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [PWM_BITS-1:0]  i_cmd_level,
  input  logic [RATE_BITS-1:0] i_cmd_rate,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic [PWM_BITS-1:0]  o_level,
  output logic                 o_done,
  output logic                 o_led
);

  logic [0:0]           state;
  logic [PWM_BITS-1:0]  target;
  logic [RATE_BITS-1:0] rate;
  logic [RATE_BITS-1:0] prescaler;
  logic [PWM_BITS-1:0]  next_level;
  logic                 step_due;

  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = (state == RAMP);

  // In RAMP the level never equals the target, so this only ever moves
  // strictly toward it and cannot wrap.
  assign next_level = (o_level < target) ? o_level + 1'b1 : o_level - 1'b1;
  assign step_due   = (prescaler == rate);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      target    <= '0;
      rate      <= '0;
      prescaler <= '0;
      o_level   <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            target    <= i_cmd_level;
            rate      <= i_cmd_rate;
            prescaler <= '0;
            if (i_cmd_level == o_level) begin
              o_done <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (i_abort) begin
            // Abort wins over a step expiring on the same edge.
            state <= IDLE;
          end else if (step_due) begin
            prescaler <= '0;
            o_level   <= next_level;
            if (next_level == target) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_duty   (o_level),
    .o_pwm    (o_led)
  );

endmodule

`default_nettype wire
